// File: rtl/spiral_ctrl.sv
// spiral_ctrl: buffers a row x col matrix arriving in raster order into an
// external 1R1W RAM, then reads it back in clockwise spiral order onto a
// valid/rdy output stream.
module spiral_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int R_WIDTH    = 3,
  parameter int C_WIDTH    = 3,
  parameter int ADDR_WIDTH = R_WIDTH + C_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [R_WIDTH-1:0]    row,
  input  logic [C_WIDTH-1:0]    col,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_rdy,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_rdy
);

  localparam int T_WIDTH = R_WIDTH + C_WIDTH;
  localparam logic [R_WIDTH-1:0] R_ONE = {{(R_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_WIDTH-1:0] C_ONE = {{(C_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [T_WIDTH-1:0] T_ONE = {{(T_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    D_RIGHT = 2'd0,
    D_DOWN  = 2'd1,
    D_LEFT  = 2'd2,
    D_UP    = 2'd3
  } dir_t;

  state_t              r_state;
  state_t              w_next_state;
  dir_t                r_dir;
  logic [R_WIDTH-1:0]  r_rows;
  logic [C_WIDTH-1:0]  r_cols;
  logic [R_WIDTH-1:0]  r_row;
  logic [C_WIDTH-1:0]  r_col;
  logic [R_WIDTH-1:0]  r_top;
  logic [R_WIDTH-1:0]  r_bot;
  logic [C_WIDTH-1:0]  r_left;
  logic [C_WIDTH-1:0]  r_right;
  logic [T_WIDTH-1:0]  r_total;
  logic [T_WIDTH-1:0]  r_issued;
  logic                r_out_valid;

  logic w_in_fire;
  logic w_last_in;
  logic w_issue;
  logic w_out_fire;
  logic w_last_out;
  logic w_zero_dim;

  assign w_zero_dim = (row == {R_WIDTH{1'b0}}) || (col == {C_WIDTH{1'b0}});
  assign w_in_fire  = (r_state == S_FILL) && data_in_valid;
  assign w_last_in  = w_in_fire && (r_row == r_rows - R_ONE) && (r_col == r_cols - C_ONE);
  assign w_issue    = (r_state == S_DRAIN) && (r_issued < r_total) &&
                      (!r_out_valid || data_out_rdy);
  assign w_out_fire = r_out_valid && data_out_rdy;
  // A handshake with nothing left to issue is necessarily the final beat.
  assign w_last_out = (r_state == S_DRAIN) && w_out_fire && (r_issued == r_total);

  assign busy           = (r_state == S_FILL) || (r_state == S_DRAIN);
  assign done           = (r_state == S_FINISH);
  assign data_in_rdy    = (r_state == S_FILL);
  assign mem_wr_en      = w_in_fire;
  assign mem_wr_addr    = {r_row, r_col};
  assign mem_wr_data    = w_in_fire ? data_in : {DATA_WIDTH{1'b0}};
  assign mem_rd_en      = w_issue;
  assign mem_rd_addr    = {r_row, r_col};
  assign data_out       = mem_rd_data;
  assign data_out_valid = r_out_valid;

  // State register.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = w_zero_dim ? S_FINISH : S_FILL;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FILL: begin
        if (w_last_in) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_FILL;
        end
      end
      S_DRAIN: begin
        if (w_last_out) begin
          w_next_state = S_FINISH;
        end else begin
          w_next_state = S_DRAIN;
        end
      end
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Dimension latch, raster fill cursor, spiral cursor/bounds and output valid.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_rows      <= '0;
      r_cols      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_top       <= '0;
      r_bot       <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_total     <= '0;
      r_issued    <= '0;
      r_dir       <= D_RIGHT;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rows   <= row;
            r_cols   <= col;
            r_total  <= {{C_WIDTH{1'b0}}, row} * {{R_WIDTH{1'b0}}, col};
            r_row    <= '0;
            r_col    <= '0;
            r_top    <= '0;
            r_bot    <= row - R_ONE;
            r_left   <= '0;
            r_right  <= col - C_ONE;
            r_dir    <= D_RIGHT;
            r_issued <= '0;
          end
        end
        S_FILL: begin
          if (w_in_fire) begin
            if (r_col == r_cols - C_ONE) begin
              r_col <= '0;
              // Wrapping the row at the last beat leaves the cursor at (0,0) for the drain.
              r_row <= (r_row == r_rows - R_ONE) ? '0 : r_row + R_ONE;
            end else begin
              r_col <= r_col + C_ONE;
            end
          end
        end
        S_DRAIN: begin
          if (w_issue) begin
            r_out_valid <= 1'b1;
            r_issued    <= r_issued + T_ONE;
            // No step after the final element, so thin matrices never wrap a bound.
            if (r_issued != r_total - T_ONE) begin
              case (r_dir)
                D_RIGHT: begin
                  if (r_col < r_right) begin
                    r_col <= r_col + C_ONE;
                  end else begin
                    r_top <= r_top + R_ONE;
                    r_dir <= D_DOWN;
                    r_row <= r_row + R_ONE;
                  end
                end
                D_DOWN: begin
                  if (r_row < r_bot) begin
                    r_row <= r_row + R_ONE;
                  end else begin
                    r_right <= r_right - C_ONE;
                    r_dir   <= D_LEFT;
                    r_col   <= r_col - C_ONE;
                  end
                end
                D_LEFT: begin
                  if (r_col > r_left) begin
                    r_col <= r_col - C_ONE;
                  end else begin
                    r_bot <= r_bot - R_ONE;
                    r_dir <= D_UP;
                    r_row <= r_row - R_ONE;
                  end
                end
                D_UP: begin
                  if (r_row > r_top) begin
                    r_row <= r_row - R_ONE;
                  end else begin
                    r_left <= r_left + C_ONE;
                    r_dir  <= D_RIGHT;
                    r_col  <= r_col + C_ONE;
                  end
                end
                default: r_dir <= D_RIGHT;
              endcase
            end
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
          end
        end
        S_FINISH: r_out_valid <= 1'b0;
        default:  r_out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/spiral_ctrl.md
Name: spiral_ctrl

Overview:
- Sequencer for the spiral-readout datapath.
- Accepts a row x col matrix in raster order over a valid/rdy stream and writes it into an external 1R1W buffer RAM.
- Then reads the buffer back in clockwise spiral order and streams the result out over a valid/rdy stream.
- Sits between the upstream matrix producer and the downstream consumer; the RAM is instantiated outside this block.

Parameters:
- DATA_WIDTH, 8, element width.
- R_WIDTH, 3, row-count and row-index width.
- C_WIDTH, 3, column-count and column-index width.
- ADDR_WIDTH, R_WIDTH+C_WIDTH, RAM address width. Address = {r_idx, c_idx}, i.e. r*2^C_WIDTH + c.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous reset, active-high (1 = reset asserted).
- start  input  1  one-cycle pulse; sampled only in IDLE.
- row  input  R_WIDTH  row count; latched on start.
- col  input  C_WIDTH  column count; latched on start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the last spiral element handshakes.
- data_in  input  DATA_WIDTH  raster-order element.
- data_in_valid  input  1  upstream valid.
- data_in_rdy  output  1  high only in FILL.
- mem_wr_en  output  1  RAM write strobe.
- mem_wr_addr  output  ADDR_WIDTH  RAM write address.
- mem_wr_data  output  DATA_WIDTH  RAM write data.
- mem_rd_en  output  1  RAM read strobe.
- mem_rd_addr  output  ADDR_WIDTH  RAM read address.
- mem_rd_data  input  DATA_WIDTH  RAM read data; valid 1 cycle after mem_rd_en; held while mem_rd_en is low.
- data_out  output  DATA_WIDTH  spiral-order element; equals mem_rd_data.
- data_out_valid  output  1  downstream valid.
- data_out_rdy  input  1  downstream ready.

Behaviour:
- Reset: state IDLE. busy, done, data_in_rdy, mem_wr_en, mem_rd_en and data_out_valid are 0. All counters, bounds and addresses are 0. Reset mid-operation aborts immediately with no done pulse; RAM contents are don't-care.
- IDLE -> FILL on start. Latch R=row, C=col, total=R*C (R_WIDTH+C_WIDTH bits). busy=1 next cycle.
- Zero dimension: if R==0 or C==0, go IDLE -> FINISH. done pulses 1 cycle after start; no RAM traffic; no output beats.
- FILL:
  - data_in_rdy=1.
  - Each data_in_valid&&data_in_rdy cycle drives mem_wr_en=1, mem_wr_addr={r,c}, mem_wr_data=data_in (combinational, same cycle).
  - Advance c; when c wraps at C-1, reset c and advance r.
  - On the beat where r==R-1 && c==C-1, go to DRAIN; data_in_rdy=0 from the next cycle.
- DRAIN:
  - Spiral cursor (r,c) starts at (0,0). Bounds: top=0, bot=R-1, left=0, right=C-1. Direction register dir in {RIGHT, DOWN, LEFT, UP}, reset RIGHT. Counter issued=0.
  - Issue condition: issued<total && (!data_out_valid || data_out_rdy). On issue, mem_rd_en=1, mem_rd_addr={r,c}, issued++, then step the cursor.
  - RIGHT: if c<right, c++; else top++, dir=DOWN, r++.
  - DOWN: if r<bot, r++; else right--, dir=LEFT, c--.
  - LEFT: if c>left, c--; else bot--, dir=UP, r--.
  - UP: if r>top, r--; else left++, dir=RIGHT, c++.
  - Cursor values after the final issue are don't-care. The step must never underflow a bound at the final element, so a 1-wide or 1-high matrix must not wrap.
  - data_out_valid is set the cycle after an issue. It clears on a handshake that has no simultaneous issue.
  - Back-to-back issue under continuous data_out_rdy gives 1 element/cycle, with first data_out_valid 1 cycle after entering DRAIN.
  - When data_out_rdy is low, hold data_out_valid and data_out stable (mem_rd_en=0 keeps RAM output held).
- FINISH: entered on the handshake of the final beat (issued==total). done=1 for one cycle, busy=0, then IDLE. A start during FILL, DRAIN or FINISH is ignored.
- No upstream beats are accepted outside FILL.

Test Plan:
- 3x3, data_in 1..9 raster, data_out_rdy=1 -> data_out 1,2,3,6,9,8,7,4,5. 9 write cycles, then 9 consecutive out beats. Single done pulse after beat 9. busy drops in the same cycle done rises.
- 2x3, data 1..6 -> 1,2,3,6,5,4. Then 4x1, data 1..4 -> 1,2,3,4. Then 1x4, data 1..4 -> 1,2,3,4. No addresses outside the matrix (check mem_rd_addr against the {r,c} range).
- 7x7, data 0..48, data_out_rdy random 50% -> output matches the software spiral model. data_out stays stable while valid && !rdy. Exactly 49 beats.
- Upstream gaps: 4x4 with data_in_valid toggling 1/0 -> exactly 16 writes at addresses {r,c} raster, and correct spiral 1,2,3,4,8,12,16,15,14,13,9,5,6,7,11,10.
- row=0, col=5, start -> done 1 cycle later. No mem_wr_en, mem_rd_en or data_out_valid. data_in_rdy stays 0.
- 3x3, assert rstn mid-DRAIN after 4 out beats -> all outputs 0 next edge, no done pulse. A new 2x2 start with data 1..4 -> 1,2,4,3.
